// File: rtl/program_sequencer_pkg.sv
// rtl/program_sequencer_pkg.sv - shared opcodes, state encoding and defaults for the program sequencer
package program_sequencer_pkg;

  localparam int REG_WIDTH_DEFAULT         = 16;
  localparam int INSTRUCTION_WIDTH_DEFAULT = 9;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_I,
    CAP_I,
    CAP_IMM,
    ISSUE,
    WAIT_DONE,
    HALTED,
    ERROR
  } state_t;

  function automatic logic is_busy_state(input state_t s);
    return !(s == IDLE || s == HALTED || s == ERROR);
  endfunction

endpackage

// File: rtl/program_sequencer_watchdog.sv
// rtl/program_sequencer_watchdog.sv - clear/enable cycle counter flagging the cycle the count reaches TIMEOUT
module seq_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] count;
  logic [W:0]   count_inc;

  // Expiry is flagged during the enabled cycle that brings the count to TIMEOUT.
  assign count_inc = {1'b0, count} + 1'b1;
  assign expired   = enable && (count_inc == (W + 1)'(TIMEOUT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count_inc[W-1:0];
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - fetches ROM instructions and issues them to the processor run/done handshake
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int REG_WIDTH         = REG_WIDTH_DEFAULT,
  parameter int INSTRUCTION_WIDTH = INSTRUCTION_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH        = 8,
  parameter int PROG_LEN          = 256,
  parameter int TIMEOUT           = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [REG_WIDTH-1:0]  rom_data,
  output logic [REG_WIDTH-1:0]  proc_din,
  output logic                  proc_run,
  input  logic                  proc_done,
  output logic                  busy,
  output logic                  halted,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] instr_count
);

  localparam logic [ADDR_WIDTH:0] PROG_END = (ADDR_WIDTH + 1)'(PROG_LEN);

  state_t                       state, next_state;
  logic [ADDR_WIDTH:0]          pc, pc_plus1, pc_next;
  logic [INSTRUCTION_WIDTH-1:0] instr_reg, rom_instr;
  logic [REG_WIDTH-1:0]         imm_reg;
  logic [2:0]                   rom_op;
  logic                         cur_mvi;
  logic                         wd_expired;

  assign rom_instr = rom_data[INSTRUCTION_WIDTH-1:0];
  assign rom_op    = rom_instr[INSTRUCTION_WIDTH-1 -: 3];
  assign cur_mvi   = (instr_reg[INSTRUCTION_WIDTH-1 -: 3] == OP_MVI);
  assign pc_plus1  = pc + 1'b1;
  assign pc_next   = cur_mvi ? pc + 2'd2 : pc_plus1;

  function automatic logic [REG_WIDTH-1:0] zext(input logic [INSTRUCTION_WIDTH-1:0] v);
    return REG_WIDTH'(v);
  endfunction

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == ISSUE),
    .enable  (state == WAIT_DONE),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, HALTED, ERROR: if (start) next_state = FETCH_I;
      FETCH_I:             next_state = CAP_I;
      CAP_I: begin
        if (rom_op == OP_HALT) begin
          next_state = HALTED;
        end else if (rom_op == OP_MVI) begin
          next_state = (pc_plus1 >= PROG_END) ? ERROR : CAP_IMM;
        end else begin
          next_state = ISSUE;
        end
      end
      CAP_IMM:             next_state = ISSUE;
      ISSUE:               next_state = WAIT_DONE;
      WAIT_DONE: begin
        if (proc_done) begin
          next_state = (pc_next >= PROG_END) ? HALTED : FETCH_I;
        end else if (wd_expired) begin
          next_state = ERROR;
        end
      end
      default:             next_state = IDLE;
    endcase
  end

  // The ROM is one cycle deep, so rom_addr is loaded a state ahead of the capture that uses it:
  // pc on entry to FETCH_I, then pc+1 during FETCH_I so an mvi immediate is ready in CAP_IMM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= '0;
      rom_addr    <= '0;
      proc_din    <= '0;
      proc_run    <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      err         <= 1'b0;
      instr_count <= '0;
      instr_reg   <= '0;
      imm_reg     <= '0;
    end else begin
      busy     <= is_busy_state(next_state);
      proc_run <= (next_state == ISSUE);
      case (state)
        IDLE, HALTED, ERROR: begin
          if (start) begin
            pc          <= '0;
            rom_addr    <= '0;
            halted      <= 1'b0;
            err         <= 1'b0;
            instr_count <= '0;
          end
        end
        FETCH_I: begin
          if (pc_plus1 < PROG_END) rom_addr <= pc_plus1[ADDR_WIDTH-1:0];
        end
        CAP_I: begin
          instr_reg <= rom_instr;
          if (rom_op == OP_HALT) begin
            halted <= 1'b1;
          end else if (rom_op == OP_MVI) begin
            if (pc_plus1 >= PROG_END) err <= 1'b1;
          end else begin
            proc_din <= zext(rom_instr);
          end
        end
        CAP_IMM: begin
          imm_reg  <= rom_data;
          proc_din <= zext(instr_reg);
        end
        ISSUE: begin
          proc_din <= cur_mvi ? imm_reg : zext(instr_reg);
        end
        WAIT_DONE: begin
          if (proc_done) begin
            if (instr_count != '1) instr_count <= instr_count + 1'b1;
            pc <= pc_next;
            if (pc_next >= PROG_END) begin
              halted <= 1'b1;
            end else begin
              rom_addr <= pc_next[ADDR_WIDTH-1:0];
            end
          end else if (wd_expired) begin
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - directed self-checking bench for program_sequencer
module tb_program_sequencer;
  import program_sequencer_pkg::*;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start1 = 1'b0, start2 = 1'b0;
  logic [7:0]  rom_addr1, rom_addr2, instr_count1, instr_count2;
  logic [15:0] rom_data1, rom_data2, proc_din1, proc_din2;
  logic        proc_run1, proc_run2, busy1, busy2, halted1, halted2, err1, err2;
  logic        m_done, m_done2;
  bit          force_done = 1'b0;

  logic [15:0] rom1 [0:255];
  logic [15:0] rom2 [0:255];

  int checks = 0;
  int errors = 0;
  int runs1 = 0;
  int runs2 = 0;
  bit addr2_hit = 1'b0;

  int          dly = 2;
  bit          never = 1'b0;
  logic [8:0]  ir;
  int          left;
  bit          pend;
  logic [15:0] regs [0:7];
  logic [15:0] bus;
  int          left2;
  bit          pend2;

  always #5 clk = ~clk;

  program_sequencer #(
    .REG_WIDTH(16), .INSTRUCTION_WIDTH(9), .ADDR_WIDTH(8), .PROG_LEN(256), .TIMEOUT(TO)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start1), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .proc_din(proc_din1), .proc_run(proc_run1), .proc_done(m_done | force_done),
    .busy(busy1), .halted(halted1), .err(err1), .instr_count(instr_count1)
  );

  program_sequencer #(
    .REG_WIDTH(16), .INSTRUCTION_WIDTH(9), .ADDR_WIDTH(8), .PROG_LEN(2), .TIMEOUT(TO)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .proc_din(proc_din2), .proc_run(proc_run2), .proc_done(m_done2),
    .busy(busy2), .halted(halted2), .err(err2), .instr_count(instr_count2)
  );

  always @(posedge clk) begin
    rom_data1 <= rom1[rom_addr1];
    rom_data2 <= rom2[rom_addr2];
    if (proc_run1) runs1 <= runs1 + 1;
    if (proc_run2) runs2 <= runs2 + 1;
    if (rom_addr2 == 8'd2) addr2_hit <= 1'b1;
  end

  // Processor model: latches the instruction on run, executes and pulses done dly cycles into the wait.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_done <= 1'b0;
      pend   <= 1'b0;
      left   <= 0;
    end else begin
      m_done <= 1'b0;
      if (proc_run1) begin
        ir   <= proc_din1[8:0];
        pend <= !never;
        left <= dly;
      end else if (pend) begin
        left <= left - 1;
        if (left == 1) begin
          m_done <= 1'b1;
          pend   <= 1'b0;
          case (ir[8:6])
            OP_MV:  begin regs[ir[5:3]] <= regs[ir[2:0]]; bus <= regs[ir[2:0]]; end
            OP_MVI: begin regs[ir[5:3]] <= proc_din1; bus <= proc_din1; end
            OP_ADD: begin
              regs[ir[5:3]] <= regs[ir[5:3]] + regs[ir[2:0]];
              bus <= regs[ir[5:3]] + regs[ir[2:0]];
            end
            OP_SUB: begin
              regs[ir[5:3]] <= regs[ir[5:3]] - regs[ir[2:0]];
              bus <= regs[ir[5:3]] - regs[ir[2:0]];
            end
            default: ;
          endcase
        end
      end
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_done2 <= 1'b0;
      pend2   <= 1'b0;
      left2   <= 0;
    end else begin
      m_done2 <= 1'b0;
      if (proc_run2) begin
        pend2 <= 1'b1;
        left2 <= 2;
      end else if (pend2) begin
        left2 <= left2 - 1;
        if (left2 == 1) begin
          m_done2 <= 1'b1;
          pend2   <= 1'b0;
        end
      end
    end
  end

  task automatic start_and_wait_run(output int lat);
    bit seen;
    seen = 1'b0;
    lat = 0;
    start1 = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      if (!seen) begin
        @(negedge clk);
        start1 = 1'b0;
        if (proc_run1) begin
          lat = i;
          seen = 1'b1;
        end
      end
    end
    start1 = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = -1;
    for (int i = 0; i < 600; i++) begin
      if (cyc < 0) begin
        if (!busy1) cyc = i;
        else @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({rom_addr1, proc_din1, proc_run1, busy1, halted1, err1, instr_count1} !== 37'd0) begin
      errors++;
      $display("FAIL reset_dut1 got addr=%h din=%h run=%b busy=%b halted=%b err=%b cnt=%h want all 0",
               rom_addr1, proc_din1, proc_run1, busy1, halted1, err1, instr_count1);
    end
    checks++;
    if ({rom_addr2, proc_din2, proc_run2, busy2, halted2, err2, instr_count2} !== 37'd0) begin
      errors++;
      $display("FAIL reset_dut2 got addr=%h din=%h run=%b busy=%b cnt=%h want all 0",
               rom_addr2, proc_din2, proc_run2, busy2, instr_count2);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_program;
    int lat, cyc, r0;
    dly = 2;
    never = 1'b0;
    r0 = runs1;
    start_and_wait_run(lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL mvi_latency got %0d want 4", lat); end
    checks++;
    if (proc_din1 !== 16'h0040) begin errors++; $display("FAIL issue_din got %h want 0040", proc_din1); end
    @(negedge clk);
    checks++;
    if (proc_run1 !== 1'b0) begin errors++; $display("FAIL run_one_cycle got %b want 0", proc_run1); end
    checks++;
    if (proc_din1 !== 16'h0005) begin errors++; $display("FAIL mvi_imm_din got %h want 0005", proc_din1); end
    wait_idle(cyc);
    checks++;
    if (cyc < 0) begin errors++; $display("FAIL prog_end got busy want idle within bound"); end
    checks++;
    if ({halted1, err1} !== 2'b10) begin errors++; $display("FAIL prog_flags got halted=%b err=%b want 1 0", halted1, err1); end
    checks++;
    if (instr_count1 !== 8'd3) begin errors++; $display("FAIL prog_count got %0d want 3", instr_count1); end
    checks++;
    if (runs1 - r0 !== 3) begin errors++; $display("FAIL prog_runs got %0d want 3", runs1 - r0); end
    checks++;
    if (bus !== 16'd10) begin errors++; $display("FAIL prog_bus got %0d want 10", bus); end
  endtask

  task automatic test_timeout;
    int lat, m, r0;
    never = 1'b1;
    r0 = runs1;
    start_and_wait_run(lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL to_latency got %0d want 4", lat); end
    @(negedge clk);
    m = 0;
    for (int i = 1; i <= 40; i++) begin
      if (m == 0) begin
        @(negedge clk);
        if (err1) m = i;
      end
    end
    checks++;
    if (m !== TO) begin errors++; $display("FAIL to_cycles got %0d want %0d", m, TO); end
    repeat (5) @(negedge clk);
    checks++;
    if ({err1, busy1, halted1} !== 3'b100) begin
      errors++; $display("FAIL to_flags got err=%b busy=%b halted=%b want 1 0 0", err1, busy1, halted1);
    end
    checks++;
    if (runs1 - r0 !== 1) begin errors++; $display("FAIL to_runs got %0d want 1", runs1 - r0); end
    checks++;
    if (instr_count1 !== 8'd0) begin errors++; $display("FAIL to_count got %0d want 0", instr_count1); end
    never = 1'b0;
  endtask

  task automatic test_done_at_expiry;
    int lat, cyc, r0;
    dly = TO - 1;
    r0 = runs1;
    start_and_wait_run(lat);
    checks++;
    if (err1 !== 1'b0) begin errors++; $display("FAIL exp_err_cleared got %b want 0", err1); end
    wait_idle(cyc);
    checks++;
    if ({halted1, err1} !== 2'b10) begin errors++; $display("FAIL exp_flags got halted=%b err=%b want 1 0", halted1, err1); end
    checks++;
    if (instr_count1 !== 8'd3 || runs1 - r0 !== 3) begin
      errors++; $display("FAIL exp_progress got cnt=%0d runs=%0d want 3 3", instr_count1, runs1 - r0);
    end
    checks++;
    if (bus !== 16'd10) begin errors++; $display("FAIL exp_bus got %0d want 10", bus); end
    dly = 2;
  endtask

  task automatic test_spurious_done;
    int cyc, lat;
    bit seen;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    lat = 0;
    seen = 1'b0;
    for (int i = 2; i <= 40; i++) begin
      if (!seen) begin
        if (proc_run1) begin lat = i; seen = 1'b1; end
        else @(negedge clk);
      end
    end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL spur_latency got %0d want 4", lat); end
    checks++;
    if (instr_count1 !== 8'd0) begin errors++; $display("FAIL spur_count got %0d want 0", instr_count1); end
    wait_idle(cyc);
    checks++;
    if (instr_count1 !== 8'd3 || halted1 !== 1'b1) begin
      errors++; $display("FAIL spur_end got cnt=%0d halted=%b want 3 1", instr_count1, halted1);
    end
  endtask

  task automatic test_start_while_busy;
    int lat, cyc, r0;
    dly = 6;
    r0 = runs1;
    start_and_wait_run(lat);
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || instr_count1 !== 8'd0) begin
      errors++; $display("FAIL busy_start got busy=%b cnt=%0d want 1 0", busy1, instr_count1);
    end
    wait_idle(cyc);
    checks++;
    if (instr_count1 !== 8'd3 || runs1 - r0 !== 3 || halted1 !== 1'b1) begin
      errors++; $display("FAIL busy_end got cnt=%0d runs=%0d halted=%b want 3 3 1", instr_count1, runs1 - r0, halted1);
    end
    dly = 2;
  endtask

  task automatic test_reset_midway;
    int lat, cyc, r0;
    bit seen;
    dly = 8;
    start_and_wait_run(lat);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({proc_run1, busy1, proc_din1, rom_addr1} !== 26'd0) begin
      errors++; $display("FAIL mid_reset got run=%b busy=%b din=%h addr=%h want 0", proc_run1, busy1, proc_din1, rom_addr1);
    end
    r0 = runs1;
    repeat (3) @(negedge clk);
    checks++;
    if (runs1 - r0 !== 0) begin errors++; $display("FAIL mid_reset_runs got %0d want 0", runs1 - r0); end
    rst = 1'b1;
    dly = 2;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    checks++;
    if (rom_addr1 !== 8'd0 || busy1 !== 1'b1) begin
      errors++; $display("FAIL restart_addr got addr=%h busy=%b want 00 1", rom_addr1, busy1);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!seen) begin
        if (proc_run1) seen = 1'b1;
        else @(negedge clk);
      end
    end
    checks++;
    if (!seen || proc_din1 !== 16'h0040) begin
      errors++; $display("FAIL restart_issue got seen=%b din=%h want 1 0040", seen, proc_din1);
    end
    wait_idle(cyc);
    checks++;
    if (instr_count1 !== 8'd3 || halted1 !== 1'b1) begin
      errors++; $display("FAIL restart_end got cnt=%0d halted=%b want 3 1", instr_count1, halted1);
    end
  endtask

  task automatic test_truncated_mvi;
    int lat, r0;
    bit seen, idle;
    r0 = runs2;
    start2 = 1'b1;
    lat = 0;
    seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (!seen) begin
        @(negedge clk);
        start2 = 1'b0;
        if (proc_run2) begin lat = i; seen = 1'b1; end
      end
    end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL trunc_latency got %0d want 3", lat); end
    idle = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!idle) begin
        if (!busy2) idle = 1'b1;
        else @(negedge clk);
      end
    end
    checks++;
    if ({idle, err2, halted2} !== 3'b110) begin
      errors++; $display("FAIL trunc_flags got idle=%b err=%b halted=%b want 1 1 0", idle, err2, halted2);
    end
    checks++;
    if (instr_count2 !== 8'd1 || runs2 - r0 !== 1) begin
      errors++; $display("FAIL trunc_count got cnt=%0d runs=%0d want 1 1", instr_count2, runs2 - r0);
    end
    checks++;
    if (addr2_hit !== 1'b0) begin errors++; $display("FAIL trunc_addr got rom_addr 2 seen want never"); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom1[i] = 16'h0000;
      rom2[i] = 16'h0000;
    end
    rom1[0] = 16'h0040;
    rom1[1] = 16'h0005;
    rom1[2] = 16'h0008;
    rom1[3] = 16'h0081;
    rom1[4] = 16'h01C0;
    rom2[0] = 16'h0008;
    rom2[1] = 16'h0040;

    test_reset();
    test_program();
    test_timeout();
    test_done_at_expiry();
    test_spurious_done();
    test_start_while_busy();
    test_reset_midway();
    test_truncated_mvi();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Instruction feeder that drives the processor's din/run inputs and consumes its done output, making it the initiator side of the processor handshake.
- Fetches 16-bit words from a synchronous program ROM and presents each instruction to the processor with a one-cycle run pulse.
- For mvi, it also prefetches the immediate word and holds it on din. It then waits for done before fetching the next instruction.
- Stops on a HALT opcode, at end of program, or on a done timeout.

Parameters:
REG_WIDTH, 16, width of ROM words and processor din
INSTRUCTION_WIDTH, 9, instruction field width, format III XXX YYY with opcode in bits [8:6]
ADDR_WIDTH, 8, ROM address width
PROG_LEN, 256, number of valid ROM words; addresses 0..PROG_LEN-1
TIMEOUT, 15, maximum cycles in WAIT_DONE before error; must be greater than 0

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse that begins execution at address 0; ignored while busy
rom_addr  out  ADDR_WIDTH  ROM read address; data returns 1 cycle later
rom_data  in  REG_WIDTH  ROM read data
proc_din  out  REG_WIDTH  to processor din
proc_run  out  1  to processor run; one-cycle pulse per instruction
proc_done  in  1  from processor done; one-cycle pulse
busy  out  1  high in every state except IDLE, HALTED and ERROR
halted  out  1  program ended normally; held until next start
err  out  1  timeout or truncated mvi; held until next start
instr_count  out  ADDR_WIDTH  number of completed instructions, saturating

Behaviour:
- Reset (rst=0, asynchronous) sets the following, all outputs registered:
  - state=IDLE, pc=0
  - rom_addr=0, proc_din=0, proc_run=0
  - busy=0, halted=0, err=0, instr_count=0
- States and transitions:
  - IDLE / HALTED / ERROR: on start, set pc=0, clear halted, err and instr_count, then go to FETCH_I.
  - FETCH_I: rom_addr=pc, then go to CAP_I.
  - CAP_I: instr_reg<=rom_data[INSTRUCTION_WIDTH-1:0].
    - Opcode 3'b111 (HALT): go to HALTED, set halted=1; the instruction is not issued.
    - Opcode 3'b001 (mvi) with pc+1 >= PROG_LEN: go to ERROR, set err=1.
    - Opcode 3'b001 (mvi) otherwise: rom_addr=pc+1, go to CAP_IMM.
    - Any other opcode: go to ISSUE.
  - CAP_IMM: imm_reg<=rom_data, go to ISSUE.
  - ISSUE: proc_din=instr_reg zero-extended, proc_run=1 for exactly this cycle, watchdog cleared, go to WAIT_DONE.
  - WAIT_DONE: proc_run=0.
    - proc_din=imm_reg if the instruction is mvi, else instr_reg. The value is held stable until done is seen.
    - On proc_done: instr_count++ (saturating at all-ones); pc += 2 for mvi, else 1.
      - If the new pc >= PROG_LEN: go to HALTED, set halted=1.
      - Otherwise: go to FETCH_I.
    - Watchdog reaching TIMEOUT without proc_done: go to ERROR, set err=1, proc_run stays 0.
- Issue latency: 3 cycles from start to proc_run (FETCH_I, CAP_I, ISSUE), 4 cycles for mvi.
- proc_done seen in any state other than WAIT_DONE is ignored.
- proc_done and watchdog expiry in the same cycle: done wins, and no error is raised.
- pc arithmetic is ADDR_WIDTH+1 bits wide, so the end-of-program compare never wraps.
- Reset mid-instruction aborts immediately with no further run pulses. The processor is expected to be reset by the same rst.
- Start pulses while busy=1 have no effect.

Decomposition:
- Shared package holds:
  - opcode constants: OP_MV=3'b000, OP_MVI=3'b001, OP_ADD=3'b010, OP_SUB=3'b011, OP_HALT=3'b111
  - state enum: IDLE, FETCH_I, CAP_I, CAP_IMM, ISSUE, WAIT_DONE, HALTED, ERROR
  - INSTRUCTION_WIDTH and REG_WIDTH defaults
- One sub-module, seq_watchdog: clear/enable counter of width clog2(TIMEOUT+1) with an expired flag.

Test Plan:
- ROM = {0x0040, 0x0005, 0x0008, 0x0081, 0x01C0} (mvi R0,#5; mv R1,R0; add R0,R1; HALT) with the real processor attached. Pulse start -> 3 run pulses, during the mvi wait proc_din=0x0005, then halted=1, instr_count=3, bus shows 10 after the add.
- Processor model that never asserts done -> err=1 exactly TIMEOUT cycles after the run pulse; no further run pulses; busy=0.
- PROG_LEN=2, ROM={0x0008, 0x0040} -> one instruction completes, then err=1 (truncated mvi); rom_addr never equals 2.
- start pulsed during WAIT_DONE -> ignored: pc and instr_count are unaffected and exactly one run pulse is seen per instruction.
- rst low in WAIT_DONE -> immediately proc_run=0, busy=0, proc_din=0. After rst high and then start, execution restarts at rom_addr=0.
- proc_done spurious in FETCH_I -> ignored. A model asserting done in the same cycle the watchdog expires -> no error, and the next fetch occurs.
